// File: rtl/cp0_irq_ctrl_if.sv
// rtl/cp0_irq_ctrl_if.sv - mtc0/mfc0 register access bus for cp0_irq_ctrl
// Purpose: groups the CP0 register read/write signals driven from the M stage.
// Signals: we (mtc0 write strobe), addr (CP0 register number),
//          wdata (mtc0 data), rdata (mfc0 data, combinational from addr).
// Modports: master (pipeline side), slave (cp0_irq_ctrl side).
interface cp0_irq_ctrl_if;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, output addr, output wdata, input rdata);
    modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/cp0_irq_ctrl.sv
// rtl/cp0_irq_ctrl.sv - CP0 status/cause/EPC registers with interrupt and exception entry
// Purpose: holds SR, Cause, EPC and PRId, samples hardware interrupt lines
//          (level or sticky rising-edge per line), raises a same-cycle
//          redirect request and performs exception entry / eret.
// Optional feature: define CP0_TIMER_COUNT_EN to add Count(9)/Compare(11)
//          with a sticky timer interrupt ORed into IP[15].
// Ports:   clk, reset (asynchronous, active-low)
//          bus        - register access (we/addr/wdata/rdata), slave side
//          pc_m, exc_code, bd, eret - M-stage exception inputs
//          hw_int     - raw hardware interrupt lines
//          req        - flush/redirect request (combinational)
//          handler_pc - handler entry PC (EXC_VECTOR)
//          epc, exl   - EPC register and SR.EXL, straight from flops
module cp0_irq_ctrl #(
    parameter int          NUM_HWINT     = 6,
    parameter logic [5:0]  IRQ_EDGE_MASK = 6'b000000,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_4180
) (
    input  logic                 clk,
    input  logic                 reset,
    cp0_irq_ctrl_if.slave        bus,
    input  logic [31:0]          pc_m,
    input  logic [4:0]           exc_code,
    input  logic                 bd,
    input  logic                 eret,
    input  logic [NUM_HWINT-1:0] hw_int,
    output logic                 req,
    output logic [31:0]          handler_pc,
    output logic [31:0]          epc,
    output logic                 exl
);

    localparam logic [31:0] PRID = 32'h4342_5541;
    localparam logic [4:0]  ADDR_COUNT   = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE = 5'd11;
    localparam logic [4:0]  ADDR_SR      = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
    localparam logic [4:0]  ADDR_EPC     = 5'd14;
    localparam logic [4:0]  ADDR_PRID    = 5'd15;
    localparam logic [NUM_HWINT-1:0] EDGE_LINES = IRQ_EDGE_MASK[NUM_HWINT-1:0];

    logic [5:0]           sr_im;
    logic                 sr_ie;
    logic                 cause_bd;
    logic [4:0]           cause_exc;
    logic [NUM_HWINT-1:0] edge_hist;
    logic [NUM_HWINT-1:0] edge_pend;
    logic                 hist_vld;
    logic [5:0]           ip;
    logic                 int_req;
    logic                 exc_req;
    logic                 wr_en;
    logic [31:0]          pc_adj;
    logic [31:0]          epc_entry;

    assign handler_pc = EXC_VECTOR;

`ifdef CP0_TIMER_COUNT_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;
    logic        timer_hit;

    assign timer_hit = (count == compare);

    // Count free-runs; a Compare write both reprograms and acknowledges the timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= 32'd0;
            compare    <= 32'd0;
            timer_pend <= 1'b0;
        end else begin
            if (wr_en && bus.addr == ADDR_COUNT) begin
                count <= bus.wdata;
            end else begin
                count <= count + 32'd1;
            end
            if (wr_en && bus.addr == ADDR_COMPARE) begin
                compare    <= bus.wdata;
                timer_pend <= 1'b0;
            end else if (timer_hit) begin
                timer_pend <= 1'b1;
            end
        end
    end
`endif

    // IP vector: level lines pass straight through, edge lines show their
    // sticky pending bit. Forced to 0 while in reset so Cause reads 0.
    always_comb begin
        ip = 6'd0;
        for (int i = 0; i < NUM_HWINT; i++) begin
            ip[i] = EDGE_LINES[i] ? edge_pend[i] : hw_int[i];
        end
`ifdef CP0_TIMER_COUNT_EN
        // Include the live compare hit so req rises in the Count==Compare cycle.
        ip[5] = ip[5] | timer_pend | timer_hit;
`endif
        if (!reset) begin
            ip = 6'd0;
        end
    end

    assign int_req = reset & sr_ie & ~exl & (|(ip & sr_im));
    assign exc_req = reset & ~exl & (exc_code != 5'd0);
    assign req     = int_req | exc_req;

    // Exception entry takes precedence over any mtc0 issued in the same cycle.
    assign wr_en = bus.we & ~req;

    assign pc_adj    = bd ? (pc_m - 32'd4) : pc_m;
    assign epc_entry = pc_adj & 32'hFFFF_FFFC;

    // Edge detection. hist_vld keeps the first clock after reset from
    // treating an already-high line as a fresh rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_hist <= '0;
            edge_pend <= '0;
            hist_vld  <= 1'b0;
        end else begin
            edge_hist <= hw_int;
            hist_vld  <= 1'b1;
            for (int i = 0; i < NUM_HWINT; i++) begin
                if (EDGE_LINES[i]) begin
                    if (hist_vld && hw_int[i] && !edge_hist[i]) begin
                        edge_pend[i] <= 1'b1;
                    end else if (wr_en && bus.addr == ADDR_CAUSE && !bus.wdata[10+i]) begin
                        edge_pend[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= 6'd0;
            sr_ie     <= 1'b0;
            exl       <= 1'b0;
            cause_bd  <= 1'b0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else if (req) begin
            exl       <= 1'b1;
            cause_exc <= int_req ? 5'd0 : exc_code;
            cause_bd  <= bd;
            epc       <= epc_entry;
        end else begin
            if (bus.we) begin
                case (bus.addr)
                    ADDR_SR: begin
                        sr_im <= bus.wdata[15:10];
                        exl   <= bus.wdata[1];
                        sr_ie <= bus.wdata[0];
                    end
                    ADDR_EPC: epc <= bus.wdata;
                    default: ;
                endcase
            end
            if (eret) begin
                exl <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        if (reset) begin
            case (bus.addr)
                ADDR_SR:      bus.rdata = {16'd0, sr_im, 8'd0, exl, sr_ie};
                ADDR_CAUSE:   bus.rdata = {cause_bd, 15'd0, ip, 3'd0, cause_exc, 2'd0};
                ADDR_EPC:     bus.rdata = epc;
                ADDR_PRID:    bus.rdata = PRID;
`ifdef CP0_TIMER_COUNT_EN
                ADDR_COUNT:   bus.rdata = count;
                ADDR_COMPARE: bus.rdata = compare;
`endif
                default:      bus.rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// tb/tb_cp0_irq_ctrl.sv - self-checking bench for cp0_irq_ctrl
module tb_cp0_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_m;
    logic [4:0]  exc_code;
    logic        bd;
    logic        eret;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc;
    logic        exl;

    cp0_irq_ctrl_if bus();

    cp0_irq_ctrl #(
        .NUM_HWINT     (6),
        .IRQ_EDGE_MASK (6'b000100),
        .EXC_VECTOR    (32'h0000_4180)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .pc_m       (pc_m),
        .exc_code   (exc_code),
        .bd         (bd),
        .eret       (eret),
        .hw_int     (hw_int),
        .req        (req),
        .handler_pc (handler_pc),
        .epc        (epc),
        .exl        (exl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        bd;
        logic        eret;
        logic [5:0]  hw;
        logic        exp_req;
        logic        exp_exl;
        logic [31:0] exp_epc;
        logic [31:0] exp_sr;
        logic [31:0] exp_cause;
    } vec_t;

    vec_t vecs[15];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc, input logic [4:0] ec, input logic b,
                         input logic er, input logic [5:0] hw);
        @(negedge clk);
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        pc_m      = pc;
        exc_code  = ec;
        bd        = b;
        eret      = er;
        hw_int    = hw;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
        eret     = 1'b0;
        exc_code = 5'd0;
    endtask

    task automatic rd(input logic [4:0] a, input string name, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(name, bus.rdata, exp);
    endtask

    function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                                input logic [31:0] pc, input logic [4:0] ec, input logic b,
                                input logic er, input logic [5:0] hw, input logic rq,
                                input logic ex, input logic [31:0] ep, input logic [31:0] sr,
                                input logic [31:0] ca);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.pc = pc; v.exc = ec; v.bd = b;
        v.eret = er; v.hw = hw; v.exp_req = rq; v.exp_exl = ex; v.exp_epc = ep;
        v.exp_sr = sr; v.exp_cause = ca;
        return v;
    endfunction

    initial begin
        //            we addr  wdata         pc            exc    bd er hw     req exl epc           sr           cause
        vecs[0]  = mk(1, 5'd12, 32'h0000_0401, 32'h0,        5'd0,  0, 0, 6'h00, 0, 0, 32'h0,        32'h401, 32'h0);
        vecs[1]  = mk(0, 5'd0,  32'h0,         32'h3008,     5'd0,  0, 0, 6'h01, 1, 1, 32'h3008,     32'h403, 32'h400);
        vecs[2]  = mk(0, 5'd0,  32'h0,         32'h0,        5'd0,  0, 1, 6'h01, 0, 0, 32'h3008,     32'h401, 32'h400);
        vecs[3]  = mk(1, 5'd12, 32'h0,         32'h0,        5'd0,  0, 0, 6'h00, 0, 0, 32'h3008,     32'h0,   32'h0);
        vecs[4]  = mk(0, 5'd0,  32'h0,         32'h3014,     5'd4,  1, 0, 6'h00, 1, 1, 32'h3010,     32'h2,   32'h8000_0010);
        vecs[5]  = mk(1, 5'd14, 32'h1234,      32'h0,        5'd4,  0, 0, 6'h00, 0, 1, 32'h1234,     32'h2,   32'h8000_0010);
        vecs[6]  = mk(0, 5'd0,  32'h0,         32'h0,        5'd0,  0, 1, 6'h00, 0, 0, 32'h1234,     32'h0,   32'h8000_0010);
        vecs[7]  = mk(1, 5'd12, 32'h0000_0401, 32'h0,        5'd0,  0, 0, 6'h00, 0, 0, 32'h1234,     32'h401, 32'h8000_0010);
        vecs[8]  = mk(1, 5'd14, 32'h5000,      32'h4000,     5'd10, 0, 0, 6'h01, 1, 1, 32'h4000,     32'h403, 32'h400);
        vecs[9]  = mk(0, 5'd0,  32'h0,         32'h0,        5'd0,  0, 1, 6'h00, 0, 0, 32'h4000,     32'h401, 32'h0);
        vecs[10] = mk(1, 5'd13, 32'hFFFF_FFFF, 32'h0,        5'd0,  0, 0, 6'h00, 0, 0, 32'h4000,     32'h401, 32'h0);
        vecs[11] = mk(0, 5'd0,  32'h0,         32'h5004,     5'd12, 0, 1, 6'h00, 1, 1, 32'h5004,     32'h403, 32'h30);
        vecs[12] = mk(0, 5'd0,  32'h0,         32'h0,        5'd0,  0, 1, 6'h00, 0, 0, 32'h5004,     32'h401, 32'h30);
        vecs[13] = mk(0, 5'd0,  32'h0,         32'h3016,     5'd3,  1, 0, 6'h00, 1, 1, 32'h3010,     32'h403, 32'h8000_000C);
        vecs[14] = mk(0, 5'd0,  32'h0,         32'h0,        5'd0,  0, 1, 6'h00, 0, 0, 32'h3010,     32'h401, 32'h8000_000C);

        reset = 1'b0; bus.we = 1'b0; bus.addr = 5'd0; bus.wdata = 32'd0;
        pc_m = 32'd0; exc_code = 5'd0; bd = 1'b0; eret = 1'b0; hw_int = 6'd0;
        #1;
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_exl", {31'd0, exl}, 32'd0);
        check("rst_epc", epc, 32'd0);
        rd(5'd12, "rst_sr", 32'd0);
        rd(5'd13, "rst_cause", 32'd0);
        rd(5'd14, "rst_epc_rd", 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 15; k++) begin
            drive(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].pc, vecs[k].exc,
                  vecs[k].bd, vecs[k].eret, vecs[k].hw);
            check($sformatf("v%0d_req", k), {31'd0, req}, {31'd0, vecs[k].exp_req});
            tick();
            check($sformatf("v%0d_exl", k), {31'd0, exl}, {31'd0, vecs[k].exp_exl});
            check($sformatf("v%0d_epc", k), epc, vecs[k].exp_epc);
            rd(5'd12, $sformatf("v%0d_sr", k), vecs[k].exp_sr);
            rd(5'd13, $sformatf("v%0d_cause", k), vecs[k].exp_cause);
        end

        // Edge line 2: pulse while EXL=1 is held, taken after eret, cleared by Cause write.
        drive(1, 5'd12, 32'h0000_1001, 32'h0, 5'd0, 0, 0, 6'h00); tick();
        drive(0, 5'd0, 32'h0, 32'h6000, 5'd1, 0, 0, 6'h00);
        check("edge_enter_req", {31'd0, req}, 32'd1);
        tick();
        drive(0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 0, 6'h04);
        check("edge_pulse_req", {31'd0, req}, 32'd0);
        tick();
        drive(0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 0, 6'h00);
        check("edge_held_req", {31'd0, req}, 32'd0);
        rd(5'd13, "edge_pend_cause", 32'h0000_1004);
        tick();
        drive(0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 1, 6'h00);
        check("edge_eret_req", {31'd0, req}, 32'd0);
        tick();
        drive(0, 5'd0, 32'h0, 32'h7000, 5'd0, 0, 0, 6'h00);
        check("edge_after_eret_req", {31'd0, req}, 32'd1);
        tick();
        check("edge_taken_epc", epc, 32'h7000);
        drive(1, 5'd13, 32'h0000_1000, 32'h0, 5'd0, 0, 0, 6'h00); tick();
        rd(5'd13, "edge_keep_cause", 32'h0000_1000);
        drive(1, 5'd13, 32'h0, 32'h0, 5'd0, 0, 0, 6'h00); tick();
        rd(5'd13, "edge_clr_cause", 32'h0);
        drive(0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 1, 6'h00); tick();
        drive(0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 0, 6'h00);
        check("edge_cleared_req", {31'd0, req}, 32'd0);

        // Reset mid-run with EXL=1, EPC=0x3010.
        drive(0, 5'd0, 32'h0, 32'h3014, 5'd4, 1, 0, 6'h00); tick();
        check("pre_rst_epc", epc, 32'h3010);
        @(negedge clk);
        reset = 1'b0; exc_code = 5'd5; hw_int = 6'h05;
        #1;
        check("mid_rst_exl", {31'd0, exl}, 32'd0);
        check("mid_rst_epc", epc, 32'd0);
        check("mid_rst_req", {31'd0, req}, 32'd0);
        rd(5'd13, "mid_rst_cause", 32'd0);
        @(negedge clk);
        reset = 1'b1; exc_code = 5'd0; hw_int = 6'h04;
        drive(0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 0, 6'h04); tick();
        drive(0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 0, 6'h04); tick();
        rd(5'd13, "rst_edge_ignored", 32'd0);
        drive(0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 0, 6'h00); tick();
        drive(0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 0, 6'h04); tick();
        rd(5'd13, "post_rst_edge", 32'h0000_1000);
        rd(5'd15, "prid", 32'h4342_5541);
        check("handler_pc", handler_pc, 32'h0000_4180);

`ifdef CP0_TIMER_COUNT_EN
        drive(1, 5'd9, 32'd0, 32'h0, 5'd0, 0, 0, 6'h00); tick();
        drive(1, 5'd11, 32'd5, 32'h0, 5'd0, 0, 0, 6'h00); tick();
        drive(1, 5'd12, 32'h0000_8001, 32'h0, 5'd0, 0, 0, 6'h00); tick();
        for (int c = 2; c < 5; c++) begin
            drive(0, 5'd0, 32'h0, 32'h8000, 5'd0, 0, 0, 6'h00);
            check($sformatf("timer_wait%0d_req", c), {31'd0, req}, 32'd0);
            tick();
        end
        drive(0, 5'd0, 32'h0, 32'h8000, 5'd0, 0, 0, 6'h00);
        rd(5'd9, "timer_count", 32'd5);
        check("timer_hit_req", {31'd0, req}, 32'd1);
        tick();
        drive(1, 5'd11, 32'h100, 32'h0, 5'd0, 0, 0, 6'h00); tick();
        rd(5'd13, "timer_clr_cause", 32'h0000_1000);
        drive(0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 1, 6'h00); tick();
        drive(0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 0, 6'h00);
        check("timer_cleared_req", {31'd0, req}, 32'd0);
`else
        drive(1, 5'd9, 32'h1234, 32'h0, 5'd0, 0, 0, 6'h00); tick();
        rd(5'd9, "no_timer_count", 32'd0);
        rd(5'd11, "no_timer_compare", 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_irq_ctrl.md
CP0_IRQ_CTRL -- requirements
Module: cp0_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_HWINT, default 6 (legal 1..6): number of hardware interrupt lines.
REQ-002 SHALL have parameter IRQ_EDGE_MASK, default 6'b000000: per-line mode; bit i=1 is edge (rising, sticky), 0 is level.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_4180: handler entry PC.
REQ-004 SHALL have ports: clk in 1, single clock; reset in 1, asynchronous, active-low.
REQ-005 SHALL have ports: we in 1, mtc0 write strobe (M stage); addr in 5, CP0 register number; wdata in 32, mtc0 data; rdata out 32, mfc0 data.
REQ-006 SHALL have ports: pc_m in 32, M-stage PC; exc_code in 5, M-stage exception code (0 = none); bd in 1, M-stage delay-slot flag; eret in 1, M-stage eret.
REQ-007 SHALL have ports: hw_int in NUM_HWINT, raw interrupt lines; req out 1, flush/redirect request; handler_pc out 32, =EXC_VECTOR; epc out 32, EPC register; exl out 1, SR.EXL.

Function
REQ-008 SHALL implement SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
REQ-009 SHALL implement Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0; IP bits at or above 10+NUM_HWINT read 0.
REQ-010 SHALL implement EPC(14), full 32 bits, and PRId(15), read-only constant 32'h4342_5541.
REQ-011 SHALL drive rdata combinationally from addr; unimplemented addresses read 0.
REQ-012 SHALL sample level lines into IP each cycle (IP[i] = hw_int[i]).
REQ-013 SHALL, for edge lines, register hw_int each cycle and set sticky pending on 0->1; pending clears only by mtc0 to Cause writing 0 to that IP bit (other Cause bits not software-writable).
REQ-014 SHALL compute int_req = IE & !EXL & |(IP & IM); exc_req = !EXL & (exc_code != 0); req = int_req | exc_req, combinational, same cycle.
REQ-015 SHALL, on a req cycle, at next edge: set EXL; Cause.ExcCode = 0 if int_req else exc_code; Cause.BD = bd; EPC = bd ? {pc_m-4}[31:2],2'b00 : {pc_m[31:2],2'b00}.
REQ-016 SHALL give interrupts priority over exceptions when both are pending in the same cycle.
REQ-017 SHALL ignore a we on a req cycle (exception entry wins over mtc0 to any register).
REQ-018 SHALL, on eret with req=0, clear EXL at next edge; eret on a req cycle is ignored.
REQ-019 SHALL, on we with req=0, update SR/EPC(/Cause IP clears) at next edge; writes to PRId ignored.
REQ-020 SHALL not assert req again while EXL=1 (no nesting); an edge pending raised while EXL=1 is retained and taken after eret.
REQ-021 SHALL drive epc and exl directly from registers (no bypass of same-cycle writes).

Reset
REQ-022 SHALL, while reset=0, asynchronously clear SR, Cause, EPC, edge history and pending (plus Count/Compare when present); req=0, exl=0, epc=0, rdata=0 for register 12/13/14.
REQ-023 SHALL not latch any edge whose rising transition coincides with reset deassertion cycle (history reloads from hw_int on first clock after reset).

Configuration
REQ-024 SHALL, with CP0_TIMER_COUNT_EN defined, add Count(9, increments every cycle, wraps 32'hFFFF_FFFF->0) and Compare(11); Count==Compare sets sticky timer pending ORed into IP[15]; mtc0 to Compare clears it; mtc0 to Count loads it.
REQ-025 SHALL, without CP0_TIMER_COUNT_EN, read addresses 9/11 as 0, ignore writes, and IP[15] reflects only hw_int[5] (if present).

Verification
REQ-026 Reset mid-run: reset=0 with EXL=1, EPC=0x3010 -> exl=0, epc=0, req=0 same cycle without a clock.
REQ-027 Level IRQ: SR=0x0000_0401, hw_int[0]=1, pc_m=0x3008, bd=0 -> req=1 same cycle; next cycle EXL=1, EPC=0x3008, ExcCode=0, req=0.
REQ-028 Delay slot exception: exc_code=5'd4, bd=1, pc_m=0x3014, IE=0 -> req=1; EPC=0x3010, BD=1, ExcCode=4.
REQ-029 Collision: int_req and exc_code=5'd10 and we to EPC=0x5000 same cycle -> ExcCode=0, EPC=pc_m, 0x5000 discarded.
REQ-030 Edge line (IRQ_EDGE_MASK bit 2=1): 1-cycle pulse on hw_int[2] while EXL=1 -> no req; after eret req=1; mtc0 Cause with IP[12]=0 clears pending.
REQ-031 With CP0_TIMER_COUNT_EN: Count=0, Compare=5, IM[15]=1, IE=1 -> req asserts in cycle Count==5; mtc0 Compare=0x100 clears IP[15].
